// File: rtl/cacheline_adaptor.sv
// Cache line adaptor: bridges a wide cache-side line interface to a
// narrow memory-side burst interface.
//
// Each line transfer is a fixed burst of BEATS beats.
//   clk, rst_n          : clock, asynchronous active-low reset
//   line_i / line_o     : write-back line in / fill line out (LINE_W bits)
//   address_i           : cache-side line address
//   read_i / write_i    : cache fill / write-back requests, held until resp_o
//   resp_o              : one-cycle completion pulse to the cache
//   burst_i / burst_o   : memory read beat in / write beat out (BURST_W bits)
//   address_o           : line-aligned memory burst address
//   read_o / write_o    : memory burst read / write request
//   resp_i              : memory beat acknowledge, one pulse per beat
module cacheline_adaptor #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BURST_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BEATS  = LINE_W / BURST_W;
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    // Clears the byte offset inside a line.
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LINE_W-1:0]   wbuf_q, wbuf_d;
    logic [LINE_W-1:0]   line_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [BURST_W-1:0]  burst_d;
    logic                resp_d, read_d, write_d;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wbuf_d  = wbuf_q;
        line_d  = line_o;
        addr_d  = address_o;
        burst_d = burst_o;

        case (state_q)
            IDLE: begin
                // Write-back wins when both requests are raised together.
                if (write_i) begin
                    state_d = WR_BURST;
                    addr_d  = address_i & ADDR_MASK;
                    cnt_d   = '0;
                    wbuf_d  = line_i;
                end else if (read_i) begin
                    state_d = RD_BURST;
                    addr_d  = address_i & ADDR_MASK;
                    cnt_d   = '0;
                end
            end
            RD_BURST: begin
                if (resp_i) begin
                    line_d[int'(cnt_q)*BURST_W +: BURST_W] = burst_i;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            WR_BURST: begin
                if (resp_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are derived from the next state so they are registered
        // yet line up with the state they describe.
        read_d  = (state_d == RD_BURST);
        write_d = (state_d == WR_BURST);
        resp_d  = (state_d == DONE);
        if (state_d == WR_BURST) begin
            burst_d = wbuf_d[int'(cnt_d)*BURST_W +: BURST_W];
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wbuf_q    <= '0;
            line_o    <= '0;
            address_o <= '0;
            burst_o   <= '0;
            resp_o    <= 1'b0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wbuf_q    <= wbuf_d;
            line_o    <= line_d;
            address_o <= addr_d;
            burst_o   <= burst_d;
            resp_o    <= resp_d;
            read_o    <= read_d;
            write_o   <= write_d;
        end
    end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have parameter LINE_W, default 256, cache-side line width in bits.
REQ-002 SHALL have parameter BURST_W, default 64, memory-side beat width; BEATS = LINE_W/BURST_W = 4.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port line_i  input  LINE_W  line from cache to be written back.
REQ-006 SHALL have port line_o  output  LINE_W  line assembled from memory for cache fill.
REQ-007 SHALL have port address_i  input  32  cache-side line address.
REQ-008 SHALL have port read_i  input  1  cache line-fill request, level, held until resp_o.
REQ-009 SHALL have port write_i  input  1  cache write-back request, level, held until resp_o.
REQ-010 SHALL have port resp_o  output  1  one-cycle completion pulse to cache.
REQ-011 SHALL have port burst_i  input  BURST_W  memory read beat data.
REQ-012 SHALL have port burst_o  output  BURST_W  memory write beat data.
REQ-013 SHALL have port address_o  output  32  memory burst address.
REQ-014 SHALL have port read_o  output  1  memory burst-read request.
REQ-015 SHALL have port write_o  output  1  memory burst-write request.
REQ-016 SHALL have port resp_i  input  1  memory beat acknowledge, one pulse per beat.

Function
REQ-017 SHALL implement FSM states IDLE, RD_BURST, WR_BURST, DONE.
REQ-018 IDLE: write_i=1 -> WR_BURST (write priority if read_i also 1); read_i=1 only -> RD_BURST; else stay.
REQ-019 On IDLE exit SHALL latch address_o = {address_i[31:5], 5'b0}, clear beat counter to 0, and (write only) latch line_i into write buffer.
REQ-020 RD_BURST: read_o=1; each cycle resp_i=1 stores burst_i into line_o bits [64*cnt+63 : 64*cnt], cnt+1.
REQ-021 WR_BURST: write_o=1; burst_o = write buffer bits [64*cnt+63 : 64*cnt]; each resp_i=1 -> cnt+1.
REQ-022 Beat counter SHALL be 2 bits; resp_i with cnt=3 -> DONE, counter wraps to 0.
REQ-023 DONE: resp_o=1 for exactly one cycle, read_o=write_o=0, then IDLE unconditionally.
REQ-024 line_o SHALL be complete and stable in the DONE cycle and held until the next read burst overwrites it.
REQ-025 read_o and write_o SHALL never be 1 simultaneously; address_o SHALL remain stable for the whole burst.
REQ-026 resp_i in IDLE or DONE SHALL be ignored (no counter or data change).
REQ-027 Cycles with resp_i=0 inside a burst SHALL hold cnt, data and outputs (unbounded stall allowed).
REQ-028 Latency: request seen in IDLE at cycle T -> read_o/write_o at T+1; resp_o one cycle after the 4th resp_i.
REQ-029 Requester SHALL see at least one IDLE cycle after resp_o before a new request is accepted.
REQ-030 Changes of line_i/address_i during a burst SHALL NOT affect the burst in progress.

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE, cnt=0, resp_o=0, read_o=0, write_o=0, address_o=0, burst_o=0, line_o=0, write buffer=0.
REQ-032 Reset asserted mid-burst SHALL abort the burst; no resp_o is produced for it; first cycle after rst_n rises is IDLE.

Verification
REQ-033 Read: address_i=0x1234_5678, read_i=1; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back -> address_o=0x1234_5660, read_o held 4 cycles, resp_o one cycle, line_o={0x44..44,0x33..33,0x22..22,0x11..11}.
REQ-034 Write: line_i={D3,D2,D1,D0}, write_i=1, resp_i on 4 consecutive cycles -> burst_o=D0,D1,D2,D3 in order, write_o then deasserts, resp_o one pulse.
REQ-035 Stalled read: resp_i gaps of 0,3,1,5 cycles between beats -> correct line_o, cnt frozen during gaps, resp_o exactly once.
REQ-036 read_i=write_i=1 in IDLE -> WR_BURST taken, read_o stays 0 throughout.
REQ-037 rst_n pulled low after beat 2 of a read -> all outputs 0 immediately, no resp_o; next read_i completes normally.
REQ-038 Spurious resp_i in IDLE followed by a read -> line_o contains only the 4 beats of the read.
